la_capture_wb: RTL and testbench



---
 rtl/la_capture_wb_if.sv | 21 ++
 rtl/la_capture_wb.sv | 142 ++++++++++++++
 tb/tb_la_capture_wb.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/la_capture_wb_if.sv
// rtl/la_capture_wb_if.sv - Wishbone slave bundle for the logic-analyzer capture engine
interface la_capture_wb_if;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_dat_i, wb_adr_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_dat_i, wb_adr_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/la_capture_wb.sv
// rtl/la_capture_wb.sv - LA capture engine: optional pattern trigger, masked lane samples into a FIFO, Wishbone drain
module la_capture_wb #(
  parameter logic [31:0] BASE_ADR = 32'h2200_0100,
  parameter int          DEPTH    = 16,
  parameter int          CNT_W    = 8
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  la_capture_wb_if.slave wb,
  input  logic [127:0]   la_data_in,
  input  logic [127:0]   la_oenb,
  input  logic [127:0]   la_iena,
  output logic           irq_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_CAPT = 2'd2, S_DONE = 2'd3} state_t;
  state_t state, state_nx;

  logic             ack_q;
  logic [31:0]      dat_q, rd_data;
  logic [1:0]       lane;
  logic             tmode, irq_en;
  logic [31:0]      tmask, tval;
  logic [CNT_W-1:0] nsamp, nsamp_eff, taken, level;
  logic [15:0]      div, div_cnt;
  logic [31:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;

  logic        valid, access, wr, rd, ctrl_wr, arm_wr, abort_wr;
  logic        push, pop, flush, trig_hit, empty, full;
  logic [7:0]  off;
  logic [31:0] sample;

  assign valid    = wb.wb_cyc_i & wb.wb_stb_i & (wb.wb_adr_i[31:8] == BASE_ADR[31:8]);
  // An access is taken only while ack is low, so every transfer costs two cycles.
  assign access   = valid & ~ack_q;
  assign wr       = access & wb.wb_we_i;
  assign rd       = access & ~wb.wb_we_i;
  assign off      = wb.wb_adr_i[7:0];
  assign ctrl_wr  = wr & (off == 8'h00) & wb.wb_sel_i[0];
  assign arm_wr   = ctrl_wr & wb.wb_dat_i[0];
  assign abort_wr = ctrl_wr & wb.wb_dat_i[1];

  assign sample    = la_data_in[{lane, 5'b0} +: 32] & la_oenb[{lane, 5'b0} +: 32]
                   & la_iena[{lane, 5'b0} +: 32];
  assign trig_hit  = ((sample ^ tval) & tmask) == 32'd0;
  assign nsamp_eff = (nsamp == '0 || nsamp > DEPTH_C) ? DEPTH_C : nsamp;
  assign empty     = (level == '0);
  assign full      = (level == DEPTH_C);
  assign push      = (state == S_CAPT) & (div_cnt == 16'd0) & ~abort_wr;
  assign pop       = rd & (off == 8'h10) & ~empty;

  always_comb begin
    state_nx = state;
    flush    = 1'b0;
    if (abort_wr) begin
      state_nx = S_IDLE;
      flush    = 1'b1;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (arm_wr) begin
          state_nx = wb.wb_dat_i[4] ? S_WAIT : S_CAPT;
          flush    = 1'b1;
        end
        S_WAIT: if (trig_hit) state_nx = S_CAPT;
        S_CAPT: if (push && (taken + CNT_W'(1)) == nsamp_eff) state_nx = S_DONE;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = 32'd0;
    case (off)
      8'h00: rd_data = {26'd0, irq_en, tmode, lane, 1'b0, state != S_IDLE};
      8'h04: rd_data = {8'd0, 8'(taken), 8'(level), 4'd0, full, empty, state};
      8'h08: rd_data = tmask;
      8'h0C: rd_data = tval;
      8'h10: rd_data = empty ? 32'd0 : mem[rd_ptr];
      8'h14: rd_data = 32'(nsamp);
      8'h18: rd_data = {16'd0, div};
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state   <= S_IDLE;
      ack_q   <= 1'b0;
      dat_q   <= 32'd0;
      lane    <= 2'd0;
      tmode   <= 1'b0;
      irq_en  <= 1'b0;
      tmask   <= 32'd0;
      tval    <= 32'd0;
      nsamp   <= '0;
      div     <= 16'd0;
      div_cnt <= 16'd0;
      taken   <= '0;
      level   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      state <= state_nx;
      ack_q <= access;
      dat_q <= access ? rd_data : 32'd0;
      if (ctrl_wr) {irq_en, tmode, lane} <= wb.wb_dat_i[5:2];
      for (int b = 0; b < 4; b++) begin
        if (wr && off == 8'h08 && wb.wb_sel_i[b]) tmask[8*b +: 8] <= wb.wb_dat_i[8*b +: 8];
        if (wr && off == 8'h0C && wb.wb_sel_i[b]) tval[8*b +: 8]  <= wb.wb_dat_i[8*b +: 8];
      end
      if (wr && off == 8'h14) nsamp <= wb.wb_dat_i[CNT_W-1:0];
      if (wr && off == 8'h18) div   <= wb.wb_dat_i[15:0];
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        level   <= '0;
        taken   <= '0;
        div_cnt <= 16'd0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
          taken  <= taken + CNT_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        level <= level + CNT_W'(push) - CNT_W'(pop);
        // Divider reloads on every push; zero on entry makes the first CAPT cycle sample.
        if (state == S_CAPT) div_cnt <= (div_cnt == 16'd0) ? div : div_cnt - 16'd1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= sample;
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign irq_o       = irq_en & (state == S_DONE);
endmodule

// File: tb/tb_la_capture_wb.sv
// tb/tb_la_capture_wb.sv - scoreboard bench for la_capture_wb with a cycle-indexed capture model
`timescale 1ns/1ps
module tb_la_capture_wb;
  localparam logic [31:0] BASE = 32'h2200_0100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  la_capture_wb_if bus();
  logic [127:0] la_data_in, la_oenb, la_iena;
  logic         irq_o;

  la_capture_wb #(.BASE_ADR(BASE), .DEPTH(16), .CNT_W(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus),
    .la_data_in(la_data_in), .la_oenb(la_oenb), .la_iena(la_iena), .irq_o(irq_o)
  );

  int tick;
  always @(posedge clk) tick <= tick + 1;

  logic [31:0] rnd [0:1023];
  int  trig_at = -1;
  bit  force_ones = 1'b0;
  int  checks = 0;
  int  passes = 0;
  bit          q_c [$];
  logic [31:0] q_v [$];
  string       q_n [$];

  // Probe value of lane l during the cycle that follows edge k.
  function automatic logic [31:0] lane_val(int k, int l);
    logic [31:0] v;
    v = rnd[(k * 4 + l) & 1023];
    if (force_ones && l == 0) v = 32'hFFFF_FFFF;
    if (k == trig_at && l == 0) v = 32'h1234_565A;
    return v;
  endfunction

  function automatic logic [31:0] model_sample(int k, int l);
    return lane_val(k, l) & la_oenb[32*l +: 32] & la_iena[32*l +: 32];
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    for (int l = 0; l < 4; l++) la_data_in[32*l +: 32] = lane_val(tick, l);
  end

  initial begin : monitor
    bit prev_ack;
    bit c;
    logic [31:0] v;
    string n;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.wb_ack_o) begin
        chk("ack_single_cycle", 32'(prev_ack), 32'd0);
        if (q_v.size() == 0) chk("unexpected_ack_queue", 32'(q_v.size()), 32'd1);
        else begin
          c = q_c.pop_front();
          v = q_v.pop_front();
          n = q_n.pop_front();
          if (c) chk(n, bus.wb_dat_o, v);
        end
      end
      prev_ack = bus.wb_ack_o;
    end
  end

  task automatic bus_xfer(bit we, logic [7:0] off, logic [31:0] d, logic [3:0] sel,
                          bit c, logic [31:0] e, string n, output int at);
    q_c.push_back(c);
    q_v.push_back(e);
    q_n.push_back(n);
    bus.wb_adr_i = BASE | {24'd0, off};
    bus.wb_dat_i = d;
    bus.wb_we_i  = we;
    bus.wb_sel_i = sel;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    at = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.wb_ack_o) begin
        at = tick;
        break;
      end
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    if (at < 0) begin
      checks++;
      $display("FAIL %s: no ack within 20 cycles", n);
      void'(q_c.pop_back());
      void'(q_v.pop_back());
      void'(q_n.pop_back());
    end
  endtask

  task automatic wr(logic [7:0] off, logic [31:0] d);
    int at;
    bus_xfer(1'b1, off, d, 4'hF, 1'b0, 32'd0, "write", at);
  endtask

  task automatic rd(logic [7:0] off, logic [31:0] e, string n);
    int at;
    bus_xfer(1'b0, off, 32'd0, 4'hF, 1'b1, e, n, at);
  endtask

  task automatic run_capture(int lane, bit tmode, bit ien, int div, int nsamp,
                             logic [31:0] tmask, logic [31:0] tval, bit drain);
    int at, k, s0, n, step, last;
    logic [31:0] words [$];
    wr(8'h08, tmask);
    wr(8'h0C, tval);
    wr(8'h14, 32'(nsamp));
    wr(8'h18, 32'(div));
    bus_xfer(1'b1, 8'h00, {26'd0, ien, tmode, 2'(lane), 2'b01}, 4'hF, 1'b0, 32'd0, "arm", at);
    chk("irq_after_arm", 32'(irq_o), 32'd0);
    n    = (nsamp == 0 || nsamp > 16) ? 16 : nsamp;
    step = div + 1;
    k    = at;
    if (tmode) begin
      while (k < at + 400 && ((model_sample(k, lane) ^ tval) & tmask) != 32'd0) k++;
      s0 = k + 1;
    end else s0 = at;
    for (int j = 0; j < n; j++) words.push_back(model_sample(s0 + j * step, lane));
    last = s0 + (n - 1) * step + 1;
    if (tmode && k > at + 3) rd(8'h04, 32'h0000_0005, "status_wait");
    while (tick < last + 1) begin
      @(posedge clk);
      #1;
    end
    chk("irq_done", 32'(irq_o), 32'(ien));
    rd(8'h04, {8'd0, 8'(n), 8'(n), 4'd0, n == 16, 1'b0, 2'd3}, "status_done");
    if (drain) begin
      foreach (words[j]) rd(8'h10, words[j], "data_word");
      rd(8'h10, 32'd0, "data_empty");
      rd(8'h04, {8'd0, 8'(n), 8'd0, 4'd0, 1'b0, 1'b1, 2'd3}, "status_drained");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int at;
    for (int i = 0; i < 1024; i++) begin
      rnd[i] = $urandom;
      if (rnd[i][7:0] == 8'h5A) rnd[i][7:0] = 8'h5B;
    end
    la_oenb = '1;
    la_iena = '1;
    la_data_in = '0;
    bus.wb_adr_i = 32'd0;
    bus.wb_dat_i = 32'd0;
    bus.wb_sel_i = 4'h0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_irq", 32'(irq_o), 32'd0);
    chk("reset_ack", 32'(bus.wb_ack_o), 32'd0);
    rd(8'h04, 32'h0000_0004, "reset_status");
    rd(8'h10, 32'd0, "reset_data_empty");
    rd(8'h00, 32'd0, "reset_ctrl");
    rd(8'h1C, 32'd0, "unmapped_read");

    bus.wb_adr_i = 32'h2200_0204;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 chk("bad_addr_noack", 32'(bus.wb_ack_o), 32'd0);
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;

    wr(8'h08, 32'hFFFF_FFFF);
    bus_xfer(1'b1, 8'h08, 32'd0, 4'b0101, 1'b0, 32'd0, "tmask_bytes", at);
    rd(8'h08, 32'hFF00_FF00, "tmask_byte_enable");
    wr(8'h00, 32'h0000_0003);
    rd(8'h04, 32'h0000_0004, "status_arm_abort_together");

    run_capture(1, 1'b0, 1'b0, 0, 4, 32'd0, 32'd0, 1'b1);
    trig_at = tick + 25;
    run_capture(0, 1'b1, 1'b0, 0, 4, 32'h0000_00FF, 32'h0000_005A, 1'b1);
    trig_at = -1;
    la_iena[31:16] = 16'h0000;
    force_ones = 1'b1;
    run_capture(0, 1'b0, 1'b0, 1, 5, 32'd0, 32'd0, 1'b1);
    force_ones = 1'b0;
    la_iena = '1;
    run_capture(2, 1'b0, 1'b0, 3, 2, 32'd0, 32'd0, 1'b1);
    run_capture(3, 1'b0, 1'b0, 0, 0, 32'd0, 32'd0, 1'b1);

    wr(8'h14, 32'd8);
    wr(8'h18, 32'd3);
    wr(8'h00, 32'h0000_0021);
    wr(8'h00, 32'h0000_0022);
    rd(8'h04, 32'h0000_0004, "status_after_abort");
    chk("irq_after_abort", 32'(irq_o), 32'd0);
    rd(8'h10, 32'd0, "data_after_abort");
    rd(8'h00, 32'h0000_0020, "ctrl_after_abort");

    run_capture(3, 1'b0, 1'b1, 0, 3, 32'd0, 32'd0, 1'b0);
    run_capture(1, 1'b0, 1'b1, 2, 6, 32'd0, 32'd0, 1'b1);

    for (int it = 0; it < 6; it++) begin
      int lane;
      logic [31:0] msk;
      lane = $urandom_range(0, 3);
      la_oenb = {$urandom, $urandom, $urandom, $urandom};
      la_iena = {$urandom, $urandom, $urandom, $urandom};
      msk = la_oenb[32*lane +: 32] & la_iena[32*lane +: 32];
      run_capture(lane, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), $urandom_range(0, 20),
                  (32'd1 << $urandom_range(0, 31)) | (32'd1 << $urandom_range(0, 31)),
                  $urandom & msk, 1'b1);
    end
    la_oenb = '1;
    la_iena = '1;

    wr(8'h14, 32'd4);
    wr(8'h18, 32'd100);
    wr(8'h00, 32'h0000_0025);
    bus.wb_adr_i = BASE | 32'h04;
    bus.wb_we_i  = 1'b0;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    at = -1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (bus.wb_ack_o) begin
        at = tick;
        break;
      end
    end
    chk("pre_reset_ack", 32'(bus.wb_ack_o), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_ack", 32'(bus.wb_ack_o), 32'd0);
    chk("async_rst_dat", bus.wb_dat_o, 32'd0);
    chk("async_rst_irq", 32'(irq_o), 32'd0);
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rd(8'h04, 32'h0000_0004, "status_after_rst");
    rd(8'h00, 32'd0, "ctrl_after_rst");
    rd(8'h14, 32'd0, "nsamp_after_rst");

    repeat (3) @(posedge clk);
    #1 chk("scoreboard_drained", 32'(q_v.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
